// File: rtl/uart_tx_buffered_if.sv
// Bus-side and line-side signal bundle for the buffered UART transmitter.
// The master side feeds words and config; the slave side is the transmitter.
interface uart_tx_buffered_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                  baudTick;
    logic [DATA_WIDTH-1:0] dataIn;
    logic                  dataValid;
    logic                  dataReady;
    logic [1:0]            parityMode;
    logic                  twoStop;
    logic                  tx;
    logic                  txBusy;
    logic [CNT_W-1:0]      fifoCount;

    modport master (
        output baudTick, dataIn, dataValid, parityMode, twoStop,
        input  dataReady, tx, txBusy, fifoCount
    );

    modport slave (
        input  baudTick, dataIn, dataValid, parityMode, twoStop,
        output dataReady, tx, txBusy, fifoCount
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed by a small TX FIFO; LSB-first frames with optional parity
// and 1/2 stop bits, sent back-to-back while words are buffered.
module uart_tx_buffered #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstN,
    uart_tx_buffered_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TICK_W = $clog2(2 * OVERSAMPLE);
    localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [TICK_W-1:0]     tick_cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en;
    logic                  par_bit;
    logic                  two_stop;
    logic                  tx_q;
    logic                  busy_q;

    logic                  push;
    logic                  pop;
    logic                  bit_end;
    logic                  stop_end;
    logic [DATA_WIDTH-1:0] head;

    assign bus.dataReady = (count != CNT_W'(FIFO_DEPTH));
    assign bus.tx        = tx_q;
    assign bus.txBusy    = busy_q;
    assign bus.fifoCount = count;

    // Push is gated by the registered full flag only, so a same-edge pop never frees room.
    assign push     = bus.dataValid && bus.dataReady;
    assign bit_end  = bus.baudTick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
    assign stop_end = bus.baudTick && (tick_cnt == (two_stop ? TICK_W'(2 * OVERSAMPLE - 1)
                                                             : TICK_W'(OVERSAMPLE - 1)));
    assign pop      = (count != '0) && ((state == IDLE) || ((state == STOP) && stop_end));
    assign head     = mem[rd_ptr];

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.dataIn;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Frame sequencer; every line-side output is a flop.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            two_stop <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else if (pop) begin
            state    <= START;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= head;
            par_en   <= (bus.parityMode == 2'b01) || (bus.parityMode == 2'b10);
            par_bit  <= (^head) ^ (bus.parityMode == 2'b10);
            two_stop <= bus.twoStop;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
        end else if ((state != IDLE) && bus.baudTick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
            case (state)
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        tx_q     <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        if (bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
                            state <= par_en ? PARITY : STOP;
                            tx_q  <= par_en ? par_bit : 1'b1;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                            shreg   <= shreg >> 1;
                            tx_q    <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        tick_cnt <= '0;
                        tx_q     <= 1'b1;
                    end
                end
                STOP: begin
                    if (stop_end) begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                        tx_q     <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
